// File: rtl/dual_ram_pingpong_ctrl.sv
// Ping-pong ownership controller for the two halves of the shared A->B dual-port RAM.
// Watches DSP A's strobes, gates its writes, and hands committed frames to DSP B.
module dual_ram_pingpong_ctrl #(
  parameter int BUF_WORDS = 32,
  parameter int INT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        iRst_n,
  input  logic        xzcs6_a,
  input  logic        we_a,
  input  logic [9:0]  addr_a,
  input  logic        release_b,
  input  logic        fail_a,
  output logic        wr_en_a,
  output logic        wbuf_a,
  output logic        rbuf_b,
  output logic        xint_b,
  output logic        overrun,
  output logic        illegal_wr,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt,
  output logic [3:0]  buf_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    READ  = 2'd3
  } half_st_e;

  localparam int         CW       = $clog2(INT_WIDTH + 1);
  localparam logic [7:0] LAST_OFF = 8'(BUF_WORDS - 1);

  logic       cs_s1, cs_s2, we_s1, we_s2, we_s3;
  logic       wr_evt, evt_q;
  logic [9:0] addr_q;

  half_st_e        st_q [2];
  half_st_e        st_d [2];
  logic            wbuf_q, wbuf_d;
  logic            rbuf_q, rbuf_d;
  logic            rd_next_q, rd_next_d;
  logic            wr_en_q, wr_en_d;
  logic            overrun_q, overrun_d;
  logic            illegal_q, illegal_d;
  logic [15:0]     frame_q, frame_d;
  logic [7:0]      drop_q, drop_d;
  logic [CW-1:0]   int_cnt_q, int_cnt_d;
  logic            fail_q;

  logic hit, sel, accept, reject, commit, other;

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      we_s1  <= 1'b1;
      we_s2  <= 1'b1;
      we_s3  <= 1'b1;
      evt_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      cs_s1  <= xzcs6_a;
      cs_s2  <= cs_s1;
      we_s1  <= we_a;
      we_s2  <= we_s1;
      we_s3  <= we_s2;
      evt_q  <= wr_evt;
      if (wr_evt) addr_q <= addr_a;
    end
  end

  assign wr_evt = we_s3 & ~we_s2 & ~cs_s2;

  assign hit    = ~addr_q[9] & (addr_q[7:0] <= LAST_OFF);
  assign sel    = addr_q[8];
  assign other  = ~wbuf_q;
  assign accept = evt_q & hit & (sel == wbuf_q) & wr_en_q & ~fail_a & (st_q[sel] == FILL);
  assign reject = evt_q & hit & ~fail_a & ~accept;
  assign commit = accept & (addr_q[7:0] == LAST_OFF);

  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      st_q[0]   <= FILL;
      st_q[1]   <= EMPTY;
      wbuf_q    <= 1'b0;
      rbuf_q    <= 1'b0;
      rd_next_q <= 1'b0;
      wr_en_q   <= 1'b1;
      overrun_q <= 1'b0;
      illegal_q <= 1'b0;
      frame_q   <= '0;
      drop_q    <= '0;
      int_cnt_q <= '0;
      fail_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      wbuf_q    <= wbuf_d;
      rbuf_q    <= rbuf_d;
      rd_next_q <= rd_next_d;
      wr_en_q   <= wr_en_d;
      overrun_q <= overrun_d;
      illegal_q <= illegal_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
      int_cnt_q <= int_cnt_d;
      fail_q    <= fail_a;
    end
  end

  always_comb begin
    st_d      = st_q;
    wbuf_d    = wbuf_q;
    rbuf_d    = rbuf_q;
    rd_next_d = rd_next_q;
    wr_en_d   = wr_en_q;
    overrun_d = overrun_q;
    illegal_d = reject;
    frame_d   = frame_q;
    drop_d    = drop_q;
    int_cnt_d = (int_cnt_q != '0) ? int_cnt_q - CW'(1) : int_cnt_q;

    if (reject && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    // Release is resolved before commit/handoff so a same-edge commit sees the freed half.
    if (release_b && st_q[rbuf_q] == READ) st_d[rbuf_q] = EMPTY;

    if (st_q[0] != READ && st_q[1] != READ && st_q[rd_next_q] == READY) begin
      st_d[rd_next_q] = READ;
      rbuf_d          = rd_next_q;
      rd_next_d       = ~rd_next_q;
      int_cnt_d       = CW'(INT_WIDTH);
    end

    if (commit) begin
      st_d[wbuf_q] = READY;
      frame_d      = frame_q + 16'd1;
      if (st_d[other] == EMPTY) begin
        st_d[other] = FILL;
        wbuf_d      = other;
      end else begin
        wr_en_d   = 1'b0;
        overrun_d = 1'b1;
      end
    end

    if (fail_a) begin
      wr_en_d = 1'b0;
    end else if (fail_q && (st_d[wbuf_q] == FILL || st_d[wbuf_q] == EMPTY)) begin
      st_d[wbuf_q] = FILL;
      wr_en_d      = 1'b1;
    end else if (!wr_en_q && st_d[other] == EMPTY) begin
      st_d[other] = FILL;
      wbuf_d      = other;
      wr_en_d     = 1'b1;
    end
  end

  assign wr_en_a    = wr_en_q;
  assign wbuf_a     = wbuf_q;
  assign rbuf_b     = rbuf_q;
  assign xint_b     = (int_cnt_q == '0);
  assign overrun    = overrun_q;
  assign illegal_wr = illegal_q;
  assign frame_cnt  = frame_q;
  assign drop_cnt   = drop_q;
  assign buf_state  = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_dual_ram_pingpong_ctrl.sv
// Scenario bench for dual_ram_pingpong_ctrl: grant order and xint_b width are scoreboarded,
// everything else is checked inline against bench-side expectations.
module tb_dual_ram_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        xzcs6_a = 1'b1;
  logic        we_a = 1'b1;
  logic [9:0]  addr_a = '0;
  logic        release_b = 1'b0;
  logic        fail_a = 1'b0;
  logic        wr_en_a, wbuf_a, rbuf_b, xint_b, overrun, illegal_wr;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
  logic [3:0]  buf_state;

  int checks = 0;
  int errors = 0;
  int ill_cycles = 0;
  int exp_rejects = 0;
  int exp_drop = 0;
  int low_len = 0;
  logic xint_prev = 1'b1;
  bit   exp_grant_q[$];

  dual_ram_pingpong_ctrl #(.BUF_WORDS(32), .INT_WIDTH(8)) dut (
    .clk(clk), .iRst_n(iRst_n), .xzcs6_a(xzcs6_a), .we_a(we_a), .addr_a(addr_a),
    .release_b(release_b), .fail_a(fail_a), .wr_en_a(wr_en_a), .wbuf_a(wbuf_a),
    .rbuf_b(rbuf_b), .xint_b(xint_b), .overrun(overrun), .illegal_wr(illegal_wr),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .buf_state(buf_state)
  );

  always #5 clk = ~clk;

  // Grant monitor: each xint_b fall pops the expected half, each rise checks the pulse width.
  always @(negedge clk) begin
    if (!iRst_n) begin
      low_len   = 0;
      xint_prev = 1'b1;
    end else begin
      if (illegal_wr) ill_cycles++;
      if (xint_b == 1'b0 && xint_prev == 1'b1) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: rbuf_b=%0d granted with no frame outstanding", rbuf_b);
        end else begin
          bit eh;
          eh = exp_grant_q.pop_front();
          if (rbuf_b !== eh) begin
            errors++;
            $display("FAIL grant_half: rbuf_b=%0d expected %0d", rbuf_b, eh);
          end
        end
      end
      if (xint_b == 1'b0) low_len++;
      if (xint_b == 1'b1 && low_len != 0) begin
        checks++;
        if (low_len !== 8) begin
          errors++;
          $display("FAIL xint_width: low for %0d cycles expected 8", low_len);
        end
        low_len = 0;
      end
      xint_prev = xint_b;
    end
  end

  task automatic count_drop();
    exp_rejects++;
    if (exp_drop < 255) exp_drop++;
  endtask

  task automatic a_write_low(input logic [9:0] a, input bit rel);
    @(negedge clk);
    addr_a  = a;
    xzcs6_a = 1'b0;
    we_a    = 1'b0;
    repeat (3) @(negedge clk);
    if (rel) release_b = 1'b1;
    @(negedge clk);
    release_b = 1'b0;
  endtask

  task automatic a_write_high();
    we_a    = 1'b1;
    xzcs6_a = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic a_write(input logic [9:0] a);
    a_write_low(a, 1'b0);
    a_write_high();
  endtask

  task automatic pulse_release();
    @(negedge clk);
    release_b = 1'b1;
    @(negedge clk);
    release_b = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    iRst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({buf_state, wbuf_a, rbuf_b, wr_en_a, xint_b, overrun, illegal_wr} !== {4'b0001, 6'b001100}) begin
      errors++;
      $display("FAIL reset_ctrl: buf_state=%b wbuf=%b rbuf=%b wr_en=%b xint=%b ovr=%b ill=%b expected 0001 0 0 1 1 0 0",
               buf_state, wbuf_a, rbuf_b, wr_en_a, xint_b, overrun, illegal_wr);
    end
    checks++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: frame_cnt=%0d drop_cnt=%0d expected 0 0", frame_cnt, drop_cnt);
    end
    iRst_n = 1'b1;
    exp_drop = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    for (int i = 0; i < 31; i++) a_write(10'h000 + 10'(i));
    exp_grant_q.push_back(1'b0);
    a_write_low(10'h01F, 1'b0);
    checks++;
    if (buf_state !== 4'b0110 || wbuf_a !== 1'b1 || wr_en_a !== 1'b1 || frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL frame_commit: buf_state=%b wbuf=%b wr_en=%b frame_cnt=%0d expected 0110 1 1 1",
               buf_state, wbuf_a, wr_en_a, frame_cnt);
    end
    @(negedge clk);
    checks++;
    if (buf_state !== 4'b0111 || rbuf_b !== 1'b0 || xint_b !== 1'b0) begin
      errors++;
      $display("FAIL frame_grant: buf_state=%b rbuf=%b xint=%b expected 0111 0 0", buf_state, rbuf_b, xint_b);
    end
    a_write_high();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 31; i++) a_write(10'h100 + 10'(i));
    exp_grant_q.push_back(1'b1);
    a_write(10'h11F);
    checks++;
    if (buf_state !== 4'b1011 || wr_en_a !== 1'b0 || overrun !== 1'b1 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL overrun_commit: buf_state=%b wr_en=%b ovr=%b frame_cnt=%0d expected 1011 0 1 2",
               buf_state, wr_en_a, overrun, frame_cnt);
    end
    a_write(10'h01F);
    count_drop();
    checks++;
    if (drop_cnt !== 8'(exp_drop) || buf_state !== 4'b1011 || wr_en_a !== 1'b0) begin
      errors++;
      $display("FAIL blocked_write: drop_cnt=%0d buf_state=%b wr_en=%b expected %0d 1011 0",
               drop_cnt, buf_state, wr_en_a, exp_drop);
    end
    pulse_release();
    checks++;
    if (buf_state !== 4'b1001 || wbuf_a !== 1'b0 || wr_en_a !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pending_handoff: buf_state=%b wbuf=%b wr_en=%b ovr=%b expected 1001 0 1 1",
               buf_state, wbuf_a, wr_en_a, overrun);
    end
    @(negedge clk);
    checks++;
    if (buf_state !== 4'b1101 || rbuf_b !== 1'b1) begin
      errors++;
      $display("FAIL regrant: buf_state=%b rbuf=%b expected 1101 1", buf_state, rbuf_b);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_illegal();
    int ill0;
    ill0 = ill_cycles;
    a_write(10'h105);
    count_drop();
    checks++;
    if (ill_cycles - ill0 !== 1 || drop_cnt !== 8'(exp_drop) || buf_state !== 4'b1101) begin
      errors++;
      $display("FAIL illegal_single: pulse_cycles=%0d drop_cnt=%0d buf_state=%b expected 1 %0d 1101",
               ill_cycles - ill0, drop_cnt, buf_state, exp_drop);
    end
    a_write(10'h050);
    a_write(10'h200);
    checks++;
    if (ill_cycles - ill0 !== 1 || drop_cnt !== 8'(exp_drop) || buf_state !== 4'b1101) begin
      errors++;
      $display("FAIL ignored_addr: pulse_cycles=%0d drop_cnt=%0d buf_state=%b expected 1 %0d 1101",
               ill_cycles - ill0, drop_cnt, buf_state, exp_drop);
    end
    for (int i = 0; i < 299; i++) begin
      a_write(10'h105);
      count_drop();
    end
    checks++;
    if (drop_cnt !== 8'd255 || exp_drop !== 255) begin
      errors++;
      $display("FAIL drop_saturate: drop_cnt=%0d expected 255", drop_cnt);
    end
    checks++;
    if (ill_cycles !== exp_rejects) begin
      errors++;
      $display("FAIL illegal_pulses: illegal_wr high %0d cycles expected %0d", ill_cycles, exp_rejects);
    end
  endtask

  task automatic test_same_cycle();
    test_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) exp_grant_q.push_back(1'b0);
      a_write(10'h000 + 10'(i));
    end
    for (int i = 0; i < 31; i++) a_write(10'h100 + 10'(i));
    exp_grant_q.push_back(1'b1);
    a_write_low(10'h11F, 1'b1);
    checks++;
    if (buf_state !== 4'b1001 || wbuf_a !== 1'b0 || wr_en_a !== 1'b1 || overrun !== 1'b0 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL same_cycle: buf_state=%b wbuf=%b wr_en=%b ovr=%b frame_cnt=%0d expected 1001 0 1 0 2",
               buf_state, wbuf_a, wr_en_a, overrun, frame_cnt);
    end
    @(negedge clk);
    checks++;
    if (buf_state !== 4'b1101 || rbuf_b !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_grant: buf_state=%b rbuf=%b expected 1101 1", buf_state, rbuf_b);
    end
    a_write_high();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_fail();
    int ill0;
    test_reset();
    ill0 = ill_cycles;
    for (int i = 0; i < 16; i++) a_write(10'h000 + 10'(i));
    @(negedge clk);
    fail_a = 1'b1;
    for (int i = 16; i < 32; i++) a_write(10'h000 + 10'(i));
    checks++;
    if (wr_en_a !== 1'b0 || buf_state !== 4'b0001 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fail_hold: wr_en=%b buf_state=%b frame_cnt=%0d expected 0 0001 0", wr_en_a, buf_state, frame_cnt);
    end
    fail_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_en_a !== 1'b1 || buf_state !== 4'b0001 || wbuf_a !== 1'b0 || drop_cnt !== 8'd0 ||
        ill_cycles !== ill0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fail_recover: wr_en=%b buf_state=%b wbuf=%b drop=%0d ill=%0d frame=%0d expected 1 0001 0 0 0 0",
               wr_en_a, buf_state, wbuf_a, drop_cnt, ill_cycles - ill0, frame_cnt);
    end
    for (int i = 0; i < 31; i++) a_write(10'h000 + 10'(i));
    exp_grant_q.push_back(1'b0);
    a_write_low(10'h01F, 1'b0);
    checks++;
    if (buf_state !== 4'b0110 || wbuf_a !== 1'b1 || frame_cnt !== 16'd1 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL fail_refill: buf_state=%b wbuf=%b frame_cnt=%0d drop=%0d expected 0110 1 1 0",
               buf_state, wbuf_a, frame_cnt, drop_cnt);
    end
    a_write_high();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_illegal();
    test_same_cycle();
    test_fail();
    checks++;
    if (exp_grant_q.size() != 0) begin
      errors++;
      $display("FAIL grant_missing: %0d expected grants never seen, expected 0", exp_grant_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_ram_pingpong_ctrl.md
Name: dual_ram_pingpong_ctrl

Overview:
Sequences ownership of the two 32-word halves of the shared dual-port RAM between DSP A (producer) and DSP B (consumer). Low half is 0x000-0x01F; high half is 0x100-0x11F.
- Tracks which half A may fill and which half B may read.
- Commits a frame when A writes the last word of its half.
- Interrupts B when a frame is ready.
- Flags overrun and illegal writes.
Sits beside the RAM core, observing A's bus strobes; gates A's writes via wr_en_a.

Parameters:
BUF_WORDS, 32, words per half; commit offset = BUF_WORDS-1.
INT_WIDTH, 8, clk cycles xint_b is held low per grant (>=1).

Ports:
clk  input  1  system clock.
iRst_n  input  1  reset, asynchronous, active-low.
xzcs6_a  input  1  DSP A chip select, active-low, asynchronous to clk.
we_a  input  1  DSP A write strobe, active-low, asynchronous to clk.
addr_a  input  10  DSP A address; stable while we_a is low.
release_b  input  1  single-cycle pulse, synchronous: B has finished reading its half.
fail_a  input  1  level, high = DSP A declared failed (watchdog).
wr_en_a  output  1  high = A holds a writable half.
wbuf_a  output  1  half A must fill: 0 = low, 1 = high.
rbuf_b  output  1  half granted to B.
xint_b  output  1  interrupt to B, active-low pulse.
overrun  output  1  sticky: A committed while no free half was available.
illegal_wr  output  1  single-cycle pulse: rejected A write.
frame_cnt  output  16  committed frames, wraps at 0xFFFF->0.
drop_cnt  output  8  rejected writes, saturates at 255.
buf_state  output  4  {half1 state, half0 state}.

Behaviour:
- Per-half 2-bit state: EMPTY=0, FILL=1, READY=2, READ=3.
- Reset values:
  - half0=FILL, half1=EMPTY; wbuf_a=0, rbuf_b=0, rd_next=0.
  - wr_en_a=1, xint_b=1, overrun=0, illegal_wr=0, counters 0.
- Synchroniser: xzcs6_a and we_a each pass through 2 flops.
- Write event: one-cycle event on the synced we_a 1->0 edge while synced xzcs6_a=0. addr_a is registered on that cycle.
  - Latency from we_a falling to event: 2-3 clk.
- Address decode:
  - addr[9:8]=0 with addr[7:0]<BUF_WORDS -> half0.
  - addr[9:8]=1 with addr[7:0]<BUF_WORDS -> half1.
  - Any other address: ignored (no count, no flag).
- Accepted write: decoded half == wbuf_a, wr_en_a=1, fail_a=0, and the half is in FILL.
- Rejected write: any decoded-half write that is not accepted and occurs while fail_a=0.
  - illegal_wr pulses for 1 cycle.
  - drop_cnt increments, saturating.
  - No state change.
- Commit: an accepted write at offset BUF_WORDS-1.
  - The half goes FILL->READY and frame_cnt increments.
  - Next cycle's handoff: if the other half is EMPTY, it goes to FILL, wbuf_a toggles, and wr_en_a stays 1.
  - Otherwise wr_en_a=0 and overrun=1 (sticky until reset).
- Pending handoff: while wr_en_a=0 and fail_a=0, the other half becoming EMPTY makes it FILL, toggles wbuf_a and sets wr_en_a=1, on the same edge.
- Grant: evaluated on registered state. When no half is in READ and half[rd_next] is READY:
  - That half goes to READ, rbuf_b=rd_next, and rd_next toggles.
  - xint_b=0 for exactly INT_WIDTH cycles.
  - The grant edge is the edge after the READY edge.
- Release: release_b while a half is in READ sends that half to EMPTY. release_b with no READ half is ignored.
- Same-cycle release and commit: release is applied first, so the commit sees EMPTY and no overrun occurs.
- Release and grant: the next grant can occur on the edge after release. The xint_b pulse counter reloads on every grant.
- fail_a=1:
  - A's writes are ignored (neither accepted nor dropped) and wr_en_a is forced 0.
  - READY/READ halves continue draining to B.
- fail_a 1->0:
  - The half at wbuf_a is forced to FILL (partial frame discarded) if it is in FILL or EMPTY.
  - wr_en_a=1 if that half is now FILL; otherwise the pending-handoff rule applies.
- Invariant: at most one half in FILL and at most one in READ.

Test Plan:
- Reset, A writes 0x000..0x01F -> buf_state=4'b0110 (half1 FILL, half0 READY) after commit; wbuf_a=1; next edge half0=READ, rbuf_b=0; xint_b low exactly 8 clk; frame_cnt=1.
- A fills both halves before any release_b -> second commit sets wr_en_a=0 and overrun=1. release_b then gives half0 EMPTY->FILL, wbuf_a=0, wr_en_a=1, and a grant of half1 with rbuf_b=1.
- A writes 0x105 while wbuf_a=0 -> illegal_wr one pulse, drop_cnt=1, buf_state unchanged. 300 such writes -> drop_cnt=255.
- Write to 0x050 or 0x200 -> no flag and no count. Write to 0x01F while wr_en_a=0 -> counted as a drop.
- Commit and release_b on the same cycle with the other half in READ -> no overrun; wbuf_a toggles.
- fail_a=1 mid-frame (offset 0x10), writes continue, then fail_a=0 -> no drops, frame_cnt unchanged, same half in FILL, wr_en_a=1. A full 32-word frame then commits normally.
